// File: rtl/mem_stage.sv
// MEM-stage datapath: data memory with byte/half/word stores, extended loads,
// and a dump FSM that streams every word to the debug unit over valid/ready.
module mem_stage #(
  parameter int BUS_SIZE      = 32,
  parameter int MEM_ADDR_SIZE = 5
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_enable,
  input  logic [2:0]               i_mem_rd_src,
  input  logic [1:0]               i_mem_wr_src,
  input  logic                     i_mem_write,
  input  logic [BUS_SIZE-1:0]      i_bus_b,
  input  logic [BUS_SIZE-1:0]      i_alu_result,
  input  logic                     i_dump_start,
  input  logic                     i_dump_ready,
  output logic [BUS_SIZE-1:0]      o_mem_rd_data,
  output logic [BUS_SIZE-1:0]      o_dump_data,
  output logic [MEM_ADDR_SIZE-1:0] o_dump_addr,
  output logic                     o_dump_valid,
  output logic                     o_dump_done,
  output logic                     o_busy
);

  localparam int DEPTH = 1 << MEM_ADDR_SIZE;
  localparam logic [MEM_ADDR_SIZE-1:0] LAST_PTR = {MEM_ADDR_SIZE{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SEND = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  state_e                   state_q, state_d;
  logic [MEM_ADDR_SIZE-1:0] ptr_q, ptr_d;
  logic [BUS_SIZE-1:0]      mem_q [DEPTH];

  logic [MEM_ADDR_SIZE-1:0] word_idx_s;
  logic [1:0]               lane_s;
  logic                     wr_en_s;
  logic [31:0]              rd_word_s;
  logic [7:0]               rd_byte_s;
  logic [15:0]              rd_half_s;
  logic [31:0]              wr_word_d;
  logic [31:0]              rd_data_s;
  logic                     unused_s;

  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sign);
    return {{24{sign & b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sign);
    return {{16{sign & h[15]}}, h};
  endfunction

  // Upper address bits wrap the address space; they are intentionally dropped.
  assign unused_s   = ^i_alu_result[BUS_SIZE-1:MEM_ADDR_SIZE+2];
  assign word_idx_s = i_alu_result[MEM_ADDR_SIZE+1:2];
  assign lane_s     = i_alu_result[1:0];
  assign wr_en_s    = i_enable & i_mem_write & (state_q == ST_IDLE);

  assign rd_word_s  = mem_q[word_idx_s];
  assign rd_byte_s  = rd_word_s[{lane_s, 3'b000} +: 8];
  assign rd_half_s  = lane_s[1] ? rd_word_s[31:16] : rd_word_s[15:0];

  // Merge the store data into the addressed word, touching only selected lanes.
  always_comb begin
    wr_word_d = rd_word_s;
    case (i_mem_wr_src)
      2'b00: wr_word_d[{lane_s, 3'b000} +: 8] = i_bus_b[7:0];
      2'b01: begin
        if (lane_s[1]) begin
          wr_word_d[31:16] = i_bus_b[15:0];
        end else begin
          wr_word_d[15:0] = i_bus_b[15:0];
        end
      end
      default: wr_word_d = i_bus_b;
    endcase
  end

  // Load extension; unused encodings fall back to a full-word load.
  always_comb begin
    rd_data_s = rd_word_s;
    case (i_mem_rd_src)
      3'b000:  rd_data_s = ext_byte(rd_byte_s, 1'b1);
      3'b001:  rd_data_s = ext_byte(rd_byte_s, 1'b0);
      3'b010:  rd_data_s = ext_half(rd_half_s, 1'b1);
      3'b011:  rd_data_s = ext_half(rd_half_s, 1'b0);
      default: rd_data_s = rd_word_s;
    endcase
  end

  assign o_mem_rd_data = rd_data_s;

  // Data memory array with lane-merged store.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k] <= '0;
      end
    end else if (wr_en_s) begin
      mem_q[word_idx_s] <= wr_word_d;
    end
  end

  // Dump FSM state and pointer registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Dump FSM next-state logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (i_dump_start) begin
          state_d = ST_SEND;
          ptr_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (i_dump_ready) begin
          if (ptr_q == LAST_PTR) begin
            state_d = ST_DONE;
          end else begin
            ptr_d = ptr_q + {{(MEM_ADDR_SIZE-1){1'b0}}, 1'b1};
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        ptr_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // Dump outputs decode directly from the state register so reset clears them at once.
  assign o_dump_valid = (state_q == ST_SEND);
  assign o_dump_done  = (state_q == ST_DONE);
  assign o_busy       = (state_q != ST_IDLE);
  assign o_dump_addr  = ptr_q;
  assign o_dump_data  = mem_q[ptr_q];

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: loads/stores, wrap, and the dump handshake.
module tb_mem_stage;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_enable;
  logic [2:0]  i_mem_rd_src;
  logic [1:0]  i_mem_wr_src;
  logic        i_mem_write;
  logic [31:0] i_bus_b;
  logic [31:0] i_alu_result;
  logic        i_dump_start;
  logic        i_dump_ready;
  logic [31:0] o_mem_rd_data;
  logic [31:0] o_dump_data;
  logic [4:0]  o_dump_addr;
  logic        o_dump_valid;
  logic        o_dump_done;
  logic        o_busy;

  int errors = 0;
  int checks = 0;

  localparam logic [2:0] LB = 3'b000, LBU = 3'b001, LH = 3'b010, LHU = 3'b011, LW = 3'b100;
  localparam logic [1:0] SB = 2'b00, SH = 2'b01, SW = 2'b10;

  mem_stage #(.BUS_SIZE(32), .MEM_ADDR_SIZE(5)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable),
    .i_mem_rd_src(i_mem_rd_src), .i_mem_wr_src(i_mem_wr_src),
    .i_mem_write(i_mem_write), .i_bus_b(i_bus_b), .i_alu_result(i_alu_result),
    .i_dump_start(i_dump_start), .i_dump_ready(i_dump_ready),
    .o_mem_rd_data(o_mem_rd_data), .o_dump_data(o_dump_data),
    .o_dump_addr(o_dump_addr), .o_dump_valid(o_dump_valid),
    .o_dump_done(o_dump_done), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data,
                       input logic [1:0] wsrc, input logic en);
    @(negedge i_clk);
    i_enable = en; i_mem_write = 1'b1; i_mem_wr_src = wsrc;
    i_bus_b = data; i_alu_result = addr;
    @(negedge i_clk);
    i_mem_write = 1'b0; i_enable = 1'b1;
  endtask

  task automatic load(input string tag, input logic [31:0] addr,
                      input logic [2:0] rsrc, input logic [31:0] exp);
    @(negedge i_clk);
    i_alu_result = addr; i_mem_rd_src = rsrc;
    #1;
    check(tag, o_mem_rd_data, exp);
  endtask

  // Run one full dump; rand_ready stalls randomly, zero_data expects an all-zero memory.
  task automatic run_dump(input bit rand_ready, input bit zero_data, input bit try_store);
    int idx = 0;
    int cyc = 0;
    logic [31:0] exp_d;
    @(negedge i_clk);
    i_dump_start = 1'b1; i_dump_ready = 1'b0;
    @(negedge i_clk);
    i_dump_start = 1'b0;
    while (idx < 32 && cyc < 2000) begin
      #1;
      exp_d = zero_data ? 32'h0 : (32'(idx) << 8);
      check("dump_valid", {31'h0, o_dump_valid}, 32'h1);
      check("dump_addr", {27'h0, o_dump_addr}, 32'(idx));
      check("dump_data", o_dump_data, exp_d);
      if (try_store && cyc == 0) begin
        i_enable = 1'b1; i_mem_write = 1'b1; i_mem_wr_src = SW;
        i_bus_b = 32'hFFFF_FFFF; i_alu_result = 32'h0000_000C;
      end else begin
        i_mem_write = 1'b0;
      end
      i_dump_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (i_dump_ready) idx++;
      @(negedge i_clk);
      cyc++;
    end
    i_dump_ready = 1'b0; i_mem_write = 1'b0;
    check("dump_count", 32'(idx), 32'd32);
    #1;
    check("done_pulse", {31'h0, o_dump_done}, 32'h1);
    check("done_valid", {31'h0, o_dump_valid}, 32'h0);
    check("done_busy", {31'h0, o_busy}, 32'h1);
    @(negedge i_clk);
    #1;
    check("done_clear", {31'h0, o_dump_done}, 32'h0);
    check("idle_busy", {31'h0, o_busy}, 32'h0);
  endtask

  initial begin
    int n;
    i_reset = 1'b1; i_enable = 1'b1; i_mem_rd_src = LW; i_mem_wr_src = SW;
    i_mem_write = 1'b0; i_bus_b = '0; i_alu_result = '0;
    i_dump_start = 1'b0; i_dump_ready = 1'b0;
    #1;
    check("rst_busy", {31'h0, o_busy}, 32'h0);
    check("rst_valid", {31'h0, o_dump_valid}, 32'h0);
    check("rst_done", {31'h0, o_dump_done}, 32'h0);
    check("rst_daddr", {27'h0, o_dump_addr}, 32'h0);
    check("rst_ddata", o_dump_data, 32'h0);
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
    for (int a = 0; a < 32; a++) load("rst_lw", 32'(a * 4), LW, 32'h0);

    store(32'h10, 32'h80FF7F01, SW, 1'b1);
    load("lb_10", 32'h10, LB, 32'h0000_0001);
    load("lb_11", 32'h11, LB, 32'h0000_007F);
    load("lb_12", 32'h12, LB, 32'hFFFF_FFFF);
    load("lbu_13", 32'h13, LBU, 32'h0000_0080);
    load("lh_12", 32'h12, LH, 32'hFFFF_80FF);
    load("lhu_12", 32'h12, LHU, 32'h0000_80FF);
    load("lh_10", 32'h11, LH, 32'h0000_7F01);
    load("lw_10", 32'h10, LW, 32'h80FF_7F01);
    load("rd_src7", 32'h10, 3'b111, 32'h80FF_7F01);

    store(32'h20, 32'h11223344, SW, 1'b1);
    store(32'h21, 32'h000000AA, SB, 1'b1);
    load("sb_merge", 32'h20, LW, 32'h1122_AA44);
    store(32'h22, 32'h0000BEEF, SH, 1'b1);
    load("sh_merge", 32'h20, LW, 32'hBEEF_AA44);
    store(32'h21, 32'h00000055, SB, 1'b0);
    load("sb_disabled", 32'h20, LW, 32'hBEEF_AA44);
    store(32'h23, 32'h12345677, SH, 1'b1);
    load("sh_low_half", 32'h20, LW, 32'h5677_AA44);

    store(32'h84, 32'hDEADBEEF, SW, 1'b1);
    load("wrap_lw", 32'h04, LW, 32'hDEAD_BEEF);

    // Read-during-write: old data before the edge, new data after it.
    @(negedge i_clk);
    i_enable = 1'b1; i_mem_write = 1'b1; i_mem_wr_src = SW;
    i_bus_b = 32'hCAFEF00D; i_alu_result = 32'h30; i_mem_rd_src = LW;
    #1;
    check("rdw_old", o_mem_rd_data, 32'h0);
    @(posedge i_clk);
    #1;
    check("rdw_new", o_mem_rd_data, 32'hCAFE_F00D);
    @(negedge i_clk);
    i_mem_write = 1'b0;

    for (int w = 0; w < 32; w++) store(32'(w * 4), 32'(w) << 8, SW, 1'b1);
    load("pre_dump_w5", 32'h14, LW, 32'h0000_0500);
    run_dump(1'b1, 1'b0, 1'b1);
    load("busy_store_dropped", 32'h0C, LW, 32'h0000_0300);

    @(negedge i_clk);
    i_dump_start = 1'b1; i_dump_ready = 1'b1;
    @(negedge i_clk);
    i_dump_start = 1'b0;
    n = 0;
    while (o_dump_addr !== 5'd7 && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    check("reach_ptr7", {27'h0, o_dump_addr}, 32'd7);
    i_dump_ready = 1'b0;
    #2;
    i_reset = 1'b1;
    #1;
    check("mid_rst_valid", {31'h0, o_dump_valid}, 32'h0);
    check("mid_rst_busy", {31'h0, o_busy}, 32'h0);
    check("mid_rst_addr", {27'h0, o_dump_addr}, 32'h0);
    check("mid_rst_data", o_dump_data, 32'h0);
    @(negedge i_clk);
    i_reset = 1'b0;
    load("mid_rst_w5", 32'h14, LW, 32'h0);
    load("mid_rst_w31", 32'h7C, LW, 32'h0);
    run_dump(1'b0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
